instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 imem_req_o  out  1  fetch request valid.
REQ-005 imem_addr_o  out  32  fetch address; bits [1:0] always 0.
REQ-006 imem_ready_i  in  1  memory accepts the request when imem_req_o && imem_ready_i ("issue").
REQ-007 imem_rvalid_i  in  1  in-order response valid, at least 1 cycle after its issue.
REQ-008 imem_rdata_i  in  32  response instruction word.
REQ-009 redirect_i  in  1  branch/jump redirect from EX; flushes the front end.
REQ-010 redirect_pc_i  in  32  redirect target.
REQ-011 id_stall_i  in  1  decode not accepting this cycle.
REQ-012 instr_valid_o  out  1  instr_o/pc_o hold a valid instruction for decode.
REQ-013 instr_o  out  32  instruction word to decode and immediate generation.
REQ-014 pc_o  out  32  address of instr_o.

Function
REQ-015 State: fetch_pc (32), 2-entry FIFO of {pc, instr}, outstanding counter (0..2), drop counter (0..2).
REQ-016 imem_req_o SHALL be 1 iff !rst_i && !redirect_i && (outstanding + FIFO count) < 2.
REQ-017 imem_addr_o SHALL equal fetch_pc; on issue fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and outstanding += 1.
REQ-018 Requests SHALL be tagged in order; each accepted response carries the pc of the oldest outstanding request.
REQ-019 Response with drop counter = 0: push {pc, imem_rdata_i} to FIFO; outstanding -= 1.
REQ-020 Response with drop counter > 0: discard data; drop -= 1; outstanding -= 1.
REQ-021 Issue and response in same cycle: outstanding unchanged.
REQ-022 imem_rvalid_i with outstanding = 0 SHALL be ignored (no state change).
REQ-023 Credit rule guarantees no FIFO overflow; push into a full FIFO cannot occur.
REQ-024 Head SHALL drive outputs: instr_valid_o = (count != 0); instr_o/pc_o = head entry; when empty instr_o = 32'h0000_0013 (NOP), pc_o = 0.
REQ-025 Consume when instr_valid_o && !id_stall_i: pop head; simultaneous push and pop allowed at any count including full.
REQ-026 Latency: issue at cycle N, response at N+k, instr_valid_o at N+k+1; back-to-back responses sustain 1 instruction/cycle with id_stall_i = 0.
REQ-027 id_stall_i held: outputs stable; fetching stops once FIFO + outstanding = 2.
REQ-028 Redirect (highest priority): fetch_pc <= {redirect_pc_i[31:2], 2'b00}; FIFO cleared (any same-cycle pop/push ignored); drop <= outstanding minus 1 if a response arrives that cycle, else outstanding; no issue that cycle.
REQ-029 Redirect while drop > 0 SHALL follow REQ-028 using current outstanding (older drops subsumed).
REQ-030 First request to the redirect target SHALL be possible the cycle after redirect_i.

Reset
REQ-031 While rst_i = 1: fetch_pc = RESET_PC, FIFO empty, outstanding = 0, drop = 0, imem_req_o = 0, instr_valid_o = 0, instr_o = 32'h0000_0013, pc_o = 0.
REQ-032 Reset mid-operation SHALL discard all outstanding and queued instructions; responses arriving in the reset cycle are ignored; first request to RESET_PC on the cycle after rst_i falls.

Verification
REQ-033 Reset release, ready=1, 1-cycle memory returning addr-derived words, stall=0 -> addresses 0,4,8,... consecutive; instr_valid_o from cycle 3, pc_o 0,4,8 one per cycle.
REQ-034 id_stall_i=1 for 5 cycles -> max 2 in flight/queued, instr_o/pc_o frozen at pc 0x8; release -> pc 0xC, 0x10 follow with no gap or duplicate.
REQ-035 Redirect to 0x0000_0102 with 2 outstanding -> next imem_addr_o 0x0000_0100; 2 stale responses dropped; first valid pc_o = 0x100.
REQ-036 Redirect in same cycle as a response and a decode pop -> FIFO empty next cycle, drop = 1, stale word never reaches instr_o.
REQ-037 fetch_pc = 0xFFFF_FFFC issued -> next imem_addr_o 0x0000_0000; rst_i pulsed with data queued -> instr_valid_o 0 next cycle, refetch from RESET_PC.
REQ-038 imem_ready_i toggling randomly, 1-4 cycle response latency, 2000 instructions -> pc_o strictly sequential, every instr_o matches scoreboard.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// tagging, 2-entry instruction queue to decode, redirect flush with stale-response drop.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        id_stall_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] fetch_pc;
   logic [31:0] fifo_pc    [2];
   logic [31:0] fifo_instr [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic [1:0]  outstanding;
   logic [1:0]  drop;

   logic        issue;
   logic        resp;
   logic        push;
   logic        pop;
   logic [1:0]  live;
   logic [31:0] resp_pc;
   logic [31:0] redirect_target;

   // Dropped requests are always the oldest in flight, so the oldest live request
   // sits 'live' words behind fetch_pc; this replaces an explicit tag queue.
   assign live    = outstanding - drop;
   assign resp_pc = fetch_pc - {28'b0, live, 2'b00};

   assign redirect_target = redirect_pc_i & ~32'd3;

   assign imem_req_o  = !rst_i && !redirect_i &&
                        (({1'b0, outstanding} + {1'b0, count}) < 3'd2);
   assign imem_addr_o = fetch_pc;

   assign issue = imem_req_o && imem_ready_i;
   assign resp  = imem_rvalid_i && (outstanding != 2'd0);
   assign push  = resp && (drop == 2'd0);

   assign instr_valid_o = !rst_i && (count != 2'd0);
   assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr] : NOP;
   assign pc_o          = instr_valid_o ? fifo_pc[rd_ptr] : 32'h0;
   assign pop           = instr_valid_o && !id_stall_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         count       <= 2'd0;
         outstanding <= 2'd0;
         drop        <= 2'd0;
      end else if (redirect_i) begin
         // Everything still in flight becomes stale; older drops are subsumed.
         fetch_pc    <= redirect_target;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         count       <= 2'd0;
         outstanding <= outstanding - {1'b0, resp};
         drop        <= outstanding - {1'b0, resp};
      end else begin
         if (issue)
            fetch_pc <= fetch_pc + 32'd4;
         outstanding <= outstanding + {1'b0, issue} - {1'b0, resp};
         if (resp && (drop != 2'd0))
            drop <= drop - 2'd1;
         if (push)
            wr_ptr <= !wr_ptr;
         if (pop)
            rd_ptr <= !rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Queue storage needs no reset: count alone qualifies the entries.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= resp_pc;
         fifo_instr[wr_ptr] <= imem_rdata_i;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch with an in-order instruction memory
// model whose words are derived from their address, so every delivered word is checkable.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ready_i  (ready),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .id_stall_i    (stall),
      .instr_valid_o (instr_valid),
      .instr_o       (instr),
      .pc_o          (pc)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          auto_mem = 1'b0;
   bit          rand_ready = 1'b0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [31:0] q_addr [$];
   int          q_due [$];
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_fetch = RESET_PC;
   int          consumed = 0;
   int          first_valid = -1;
   int          rel_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
   endfunction

   task automatic adv();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drv(input logic rv, input logic [31:0] rd, input logic rdr,
                      input logic [31:0] rpc, input logic stl);
      rvalid      = rv;
      rdata       = rd;
      redirect    = rdr;
      redirect_pc = rpc;
      stall       = stl;
      #1;
   endtask

   // One cycle with the memory model and scoreboard active.
   task automatic cycle();
      if (q_due.size() != 0 && q_due[0] <= cyc) begin
         rvalid = 1'b1;
         rdata  = word(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end else begin
         rvalid = 1'b0;
         rdata  = 32'hDEAD_BEEF;
      end
      if (rand_ready)
         ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rst || redirect)
         check("req_blocked", 32'(imem_req), 32'h0);
      if (!rst)
         check("fetch_addr", imem_addr, exp_fetch);
      if (instr_valid) begin
         check("pc_seq", pc, exp_pc);
         check("instr_word", instr, word(pc));
         if (first_valid < 0)
            first_valid = cyc - rel_cyc;
      end
      if (rst) begin
         q_addr.delete();
         q_due.delete();
         exp_pc    = RESET_PC;
         exp_fetch = RESET_PC;
      end else if (redirect) begin
         exp_pc    = redirect_pc & ~32'd3;
         exp_fetch = redirect_pc & ~32'd3;
      end else begin
         if (imem_req && ready) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            exp_fetch += 32'd4;
         end
         if (instr_valid && !stall) begin
            exp_pc += 32'd4;
            consumed++;
         end
      end
      adv();
   endtask

   initial begin
      rst = 1'b1; ready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
      @(negedge clk);

      // Reset state
      #1;
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_pc", pc, 32'h0);
      adv();
      #1;
      check("rst_req2", 32'(imem_req), 32'h0);
      check("rst_addr", imem_addr, RESET_PC);
      adv();

      // Sequential fetch, 1-cycle memory
      auto_mem = 1'b1; ready = 1'b1; lat_min = 1; lat_max = 1;
      rst = 1'b0; rel_cyc = cyc; first_valid = -1;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid && pc == 32'h8) break;
         cycle();
      end
      check("first_latency", 32'(first_valid), 32'd2);
      check("reach_pc8", pc, 32'h8);

      // Decode stall
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(instr_valid), 32'h1);
         check("stall_pc", pc, 32'h8);
         cycle();
      end
      check("stall_req", 32'(imem_req), 32'h0);
      check("stall_inflight", 32'(q_addr.size()), 32'h0);
      stall = 1'b0;
      repeat (12) cycle();

      // Redirect with two requests outstanding
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 30; i++) begin
         if (q_addr.size() == 2) break;
         cycle();
      end
      check("two_outstanding", 32'(q_addr.size()), 32'd2);
      redirect = 1'b1; redirect_pc = 32'h0000_0102;
      cycle();
      redirect = 1'b0;
      check("redir_addr", imem_addr, 32'h0000_0100);
      for (int i = 0; i < 40; i++) begin
         if (instr_valid) break;
         cycle();
      end
      check("redir_first_pc", pc, 32'h0000_0100);
      repeat (10) cycle();

      // Hand-driven memory: redirect/response/pop collisions and drop accounting
      auto_mem = 1'b0; ready = 1'b1;
      rst = 1'b1; drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); adv();
      rst = 1'b0;
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("m0_req", 32'(imem_req), 32'h1); check("m0_addr", imem_addr, 32'h0); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("m1_addr", imem_addr, 32'h4); adv();
      drv(1'b1, word(32'h0), 1'b0, 32'h0, 1'b0);
      check("m2_credit", 32'(imem_req), 32'h0); adv();
      drv(1'b1, word(32'h4), 1'b1, 32'h0000_0202, 1'b0);
      check("m3_valid", 32'(instr_valid), 32'h1);
      check("m3_pc", pc, 32'h0);
      check("m3_instr", instr, word(32'h0));
      check("m3_req", 32'(imem_req), 32'h0); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("m4_flushed", 32'(instr_valid), 32'h0);
      check("m4_req", 32'(imem_req), 32'h1);
      check("m4_addr", imem_addr, 32'h0000_0200); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("m5_addr", imem_addr, 32'h0000_0204); adv();
      drv(1'b1, word(32'h0000_0200), 1'b1, 32'h0000_0301, 1'b0);
      check("m6_req", 32'(imem_req), 32'h0); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("m7_valid", 32'(instr_valid), 32'h0);
      check("m7_addr", imem_addr, 32'h0000_0300);
      check("m7_req", 32'(imem_req), 32'h1); adv();
      drv(1'b1, word(32'h0000_0204), 1'b0, 32'h0, 1'b0);
      check("m8_req", 32'(imem_req), 32'h0); adv();
      ready = 1'b0;
      drv(1'b1, word(32'h0000_0300), 1'b0, 32'h0, 1'b0);
      check("m9_stale_dropped", 32'(instr_valid), 32'h0);
      check("m9_addr", imem_addr, 32'h0000_0304); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check("m10_valid", 32'(instr_valid), 32'h1);
      check("m10_pc", pc, 32'h0000_0300);
      check("m10_instr", instr, word(32'h0000_0300)); adv();
      drv(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
      check("m11_pc", pc, 32'h0000_0300); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("m12_instr", instr, word(32'h0000_0300)); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("m13_spurious_ignored", 32'(instr_valid), 32'h0);
      check("m13_nop", instr, 32'h0000_0013);
      check("m13_pc", pc, 32'h0); adv();

      // Address wrap, then reset with data queued
      ready = 1'b1;
      drv(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("w1_addr", imem_addr, 32'hFFFF_FFFC); adv();
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("w2_wrap_addr", imem_addr, 32'h0); check("w2_req", 32'(imem_req), 32'h1); adv();
      drv(1'b1, word(32'hFFFF_FFFC), 1'b0, 32'h0, 1'b0); adv();
      drv(1'b1, word(32'h0), 1'b0, 32'h0, 1'b1);
      check("w4_pc", pc, 32'hFFFF_FFFC);
      check("w4_instr", instr, word(32'hFFFF_FFFC)); adv();
      rst = 1'b1;
      drv(1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1);
      check("w5_rst_req", 32'(imem_req), 32'h0);
      check("w5_rst_valid", 32'(instr_valid), 32'h0);
      check("w5_rst_instr", instr, 32'h0000_0013); adv();
      rst = 1'b0; ready = 1'b0;
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("w6_valid", 32'(instr_valid), 32'h0);
      check("w6_req", 32'(imem_req), 32'h1);
      check("w6_addr", imem_addr, RESET_PC); adv();

      // Random ready, 1-4 cycle latency, stalls and redirects
      auto_mem = 1'b1; rand_ready = 1'b1; lat_min = 1; lat_max = 4;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0;
      repeat (2) cycle();
      rst = 1'b0; consumed = 0;
      for (int i = 0; i < 30000 && consumed < 2000; i++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 63) == 0);
         redirect_pc = $urandom;
         cycle();
      end
      redirect = 1'b0; stall = 1'b0;
      check("rand_progress", 32'(consumed >= 2000), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
